// File: rtl/excess3_to_bcd_serial.sv
// Serial Excess-3 to packed BCD decoder: one digit per clock, LSB digit first,
// with valid/ready on both sides and first-invalid-digit reporting.
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   CONV  | decoding shreg[3:0] into digit slot cnt
//   DONE  | result presented, outputs frozen until out_ready
module excess3_to_bcd_serial #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   Xs,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  err,
  output logic [IDXW-1:0]       err_pos
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state, state_nxt;
  logic [4*DIGITS-1:0]   shreg;
  logic [IDXW-1:0]       cnt;
  logic [3:0]            digit;
  logic                  legal;
  logic                  last;

  assign digit     = shreg[3:0];
  assign legal     = (digit >= 4'd3) && (digit <= 4'd12);
  assign last      = (cnt == IDXW'(DIGITS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CONV;
      CONV:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      cnt     <= '0;
      BCD     <= '0;
      err     <= 1'b0;
      err_pos <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= Xs;
            cnt     <= '0;
            BCD     <= '0;
            err     <= 1'b0;
            err_pos <= '0;
          end
        end
        CONV: begin
          if (legal) begin
            BCD[4*cnt +: 4] <= digit - 4'd3;
          end else begin
            BCD[4*cnt +: 4] <= 4'hF;
            // only the lowest-indexed bad digit is reported
            if (!err) begin
              err     <= 1'b1;
              err_pos <= cnt;
            end
          end
          shreg <= shreg >> 4;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Directed-vector bench for excess3_to_bcd_serial (DIGITS=4).
module tb_excess3_to_bcd_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Xs;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] BCD;
  logic        err;
  logic [1:0]  err_pos;

  int compared   = 0;
  int mismatched = 0;

  excess3_to_bcd_serial #(.DIGITS(4), .IDXW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Xs(Xs),
    .out_valid(out_valid), .out_ready(out_ready), .BCD(BCD), .err(err), .err_pos(err_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept one word and count edges until out_valid (20 means timed out).
  task automatic run_word(input logic [15:0] x, output int edges);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    Xs       = x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    Xs       = 16'hxxxx;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid) edges++;
    end
    if (!out_valid) edges = 20;
  endtask

  task automatic test_reset;
    #3;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || BCD !== 16'h0000 || err !== 1'b0 || err_pos !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b BCD=%h err=%b err_pos=%0d, want 1 0 0000 0 0",
               in_ready, out_valid, BCD, err, err_pos);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    Xs       = 16'hC63B;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_busy: in_ready=%b want 0", in_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (out_valid !== (i == 4)) begin
        mismatched++;
        $display("FAIL basic_latency: edge %0d out_valid=%b want %b", i, out_valid, (i == 4));
      end
    end
    compared++;
    if (BCD !== 16'h9308 || err !== 1'b0 || err_pos !== 2'd0) begin
      mismatched++;
      $display("FAIL basic_result: BCD=%h err=%b err_pos=%0d want 9308 0 0", BCD, err, err_pos);
    end
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || BCD !== 16'h9308) begin
      mismatched++;
      $display("FAIL basic_return_idle: out_valid=%b in_ready=%b BCD=%h want 0 1 9308", out_valid, in_ready, BCD);
    end
  endtask

  task automatic test_invalid;
    int edges;
    run_word(16'h4D53, edges);
    compared++;
    if (edges !== 4 || BCD !== 16'h1F20 || err !== 1'b1 || err_pos !== 2'd2) begin
      mismatched++;
      $display("FAIL invalid_one: edges=%0d BCD=%h err=%b err_pos=%0d want 4 1f20 1 2", edges, BCD, err, err_pos);
    end
    run_word(16'h0F33, edges);
    compared++;
    if (edges !== 4 || BCD !== 16'hFF00 || err !== 1'b1 || err_pos !== 2'd2) begin
      mismatched++;
      $display("FAIL invalid_two: edges=%0d BCD=%h err=%b err_pos=%0d want 4 ff00 1 2", edges, BCD, err, err_pos);
    end
  endtask

  task automatic test_legal_range;
    logic [15:0] xv [3] = '{16'h3333, 16'hCCCC, 16'h789A};
    logic [15:0] bv [3] = '{16'h0000, 16'h9999, 16'h4567};
    int edges;
    for (int i = 0; i < 3; i++) begin
      run_word(xv[i], edges);
      compared++;
      if (edges !== 4 || BCD !== bv[i] || err !== 1'b0 || err_pos !== 2'd0) begin
        mismatched++;
        $display("FAIL legal_%h: edges=%0d BCD=%h err=%b err_pos=%0d want 4 %h 0 0",
                 xv[i], edges, BCD, err, err_pos, bv[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    @(negedge clk);
    out_ready = 1'b0;
    run_word(16'hC63B, edges);
    compared++;
    if (edges !== 4 || BCD !== 16'h9308) begin
      mismatched++;
      $display("FAIL bp_first: edges=%0d BCD=%h want 4 9308", edges, BCD);
    end
    in_valid = 1'b1;
    Xs       = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (BCD !== 16'h9308 || in_ready !== 1'b0 || out_valid !== 1'b1 || err !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold: cycle %0d BCD=%h in_ready=%b out_valid=%b err=%b want 9308 0 1 0",
                 i, BCD, in_ready, out_valid, err);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || BCD !== 16'h9308) begin
      mismatched++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b BCD=%h want 1 0 9308", in_ready, out_valid, BCD);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b0 || BCD !== 16'h0000) begin
      mismatched++;
      $display("FAIL bp_second_accept: in_ready=%b BCD=%h want 0 0000", in_ready, BCD);
    end
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid) edges++;
    end
    compared++;
    if (edges !== 4 || BCD !== 16'h0000 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_second_result: edges=%0d BCD=%h err=%b want 4 0000 0", edges, BCD, err);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_midconv;
    int edges;
    @(negedge clk);
    in_valid = 1'b1;
    Xs       = 16'hC63B;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || BCD !== 16'h0000 || err !== 1'b0 || err_pos !== 2'd0) begin
      mismatched++;
      $display("FAIL rst_async: in_ready=%b out_valid=%b BCD=%h err=%b err_pos=%0d want 1 0 0000 0 0",
               in_ready, out_valid, BCD, err, err_pos);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || BCD !== 16'h0000) begin
      mismatched++;
      $display("FAIL rst_discard: in_ready=%b out_valid=%b BCD=%h want 1 0 0000", in_ready, out_valid, BCD);
    end
    run_word(16'h4D53, edges);
    compared++;
    if (edges !== 4 || BCD !== 16'h1F20 || err !== 1'b1 || err_pos !== 2'd2) begin
      mismatched++;
      $display("FAIL rst_next_word: edges=%0d BCD=%h err=%b err_pos=%0d want 4 1f20 1 2", edges, BCD, err, err_pos);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Xs        = 16'h0000;
    test_reset;
    test_basic;
    test_invalid;
    test_legal_range;
    test_back_to_back;
    test_reset_midconv;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
